ravan_axi_master: RTL and testbench
===================================

RAVAN_AXI_MASTER -- requirements
Module: ravan_axi_master

Interface
REQ-001 Parameters: TIMEOUT, default 255 (8-bit), is the per-phase watchdog limit in cycles; KEY_W, default 512, is the key width.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  host request present.
REQ-005 cmd_ready  output  1  block can accept a request.
REQ-006 cmd_data  input  64  plaintext/ciphertext word.
REQ-007 cmd_addr  input  16  target address.
REQ-008 cmd_key  input  KEY_W  key for this request.
REQ-009 res_valid  output  1  result word held.
REQ-010 res_ready  input  1  host consumes result.
REQ-011 res_data  output  64  engine result.
REQ-012 res_err  output  1  result aborted by watchdog (res_data = 0).
REQ-013 awvalid, wvalid, bready, arvalid, rready  output  1 each  engine-side handshake drives.
REQ-014 awready, wready, bvalid, arready, rvalid  input  1 each  engine-side handshake returns.
REQ-015 eng_data  output  64, eng_addr  output  16, eng_key  output  KEY_W  request fields, stable from AW entry to IDLE return.
REQ-016 eng_rdata  input  64  engine output word.
REQ-017 job_cnt  output  16  completed (non-error) jobs, wraps at 0xFFFF->0.

Function
REQ-018 States: IDLE, AW, W, B, AR, R, CAP, HOLD.
REQ-019 cmd_ready = 1 only in IDLE; in IDLE, cmd_valid&&cmd_ready registers cmd_data/addr/key into eng_* and enters AW.
REQ-020 AW: awvalid=1 until a cycle with awvalid&&awready, then enter W.
REQ-021 W: wvalid=1 until wvalid&&wready, then enter B.
REQ-022 B: bready=1 until bvalid&&bready, then enter AR.
REQ-023 AR: arvalid=1 until arvalid&&arready, then enter R.
REQ-024 R: rready=0 until rvalid=1; the first cycle rvalid is seen, rready=1 for exactly one cycle, then enter CAP.
REQ-025 CAP: one wait cycle; at its end, res_data <= eng_rdata, res_valid <= 1, res_err <= 0, job_cnt += 1, then enter HOLD.
REQ-026 HOLD: res_valid held; on res_valid&&res_ready, res_valid <= 0 and enter IDLE; no new request is accepted while res_valid=1.
REQ-027 Handshake outputs are registered, at most one is high in any cycle, and each is deasserted the cycle after its handshake completes.
REQ-028 Watchdog: an 8-bit counter clears on every state entry and increments each cycle in AW, W, B, AR, R.
REQ-029 If the counter reaches TIMEOUT before the handshake, all handshake outputs <= 0, res_data <= 0, res_err <= 1, res_valid <= 1, job_cnt unchanged, and the block enters HOLD.
REQ-030 A handshake completing in the same cycle the counter reaches TIMEOUT wins: no error is flagged.
REQ-031 Engine returns asserted outside their phase are ignored.
REQ-032 A single command-to-result latency with zero-wait engine responses is 2 cycles per AW/W/B/AR phase + 2 (R) + 1 (CAP) = 11 cycles from the accept edge to res_valid.

Reset
REQ-033 When rst=0: state=IDLE, all handshake outputs=0, res_valid=0, res_err=0, res_data=0, job_cnt=0, watchdog=0, eng_* =0; cmd_ready=1 on the first cycle after release.
REQ-034 Reset asserted mid-transaction aborts immediately with no result produced; the engine must be reset concurrently.

Verification
REQ-035 Nominal: cmd_data=0x0123456789ABCDEF, addr=0x0010, engine model returns 0xDEADBEEFCAFEF00D -> res_valid with that data, res_err=0, job_cnt=1.
REQ-036 Back-pressure: res_ready held 0 for 20 cycles with a second cmd_valid pending -> cmd_ready=0 throughout; second job starts only after res_ready=1.
REQ-037 Timeout: engine never asserts arready, TIMEOUT=16 -> res_valid with res_err=1, res_data=0, arvalid=0, job_cnt unchanged.
REQ-038 Tie: wready arrives on the exact cycle the counter reaches TIMEOUT -> no error, block proceeds to B.
REQ-039 Reset mid-W: rst pulsed low while wvalid=1 -> all outputs at reset values asynchronously; the next command completes normally.
REQ-040 Wrap: job_cnt preloaded via 65535 jobs (or force) -> next success yields job_cnt=0.

Source files
------------

// File: rtl/ravan_axi_master.sv
// Single-outstanding job sequencer: drives an engine through AW/W/B/AR/R handshakes
// with a per-phase watchdog and returns one result word per command.
module ravan_axi_master #(
    parameter int TIMEOUT = 255,
    parameter int KEY_W   = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [63:0]      cmd_data,
    input  logic [15:0]      cmd_addr,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_err,
    output logic             awvalid,
    output logic             wvalid,
    output logic             bready,
    output logic             arvalid,
    output logic             rready,
    input  logic             awready,
    input  logic             wready,
    input  logic             bvalid,
    input  logic             arready,
    input  logic             rvalid,
    output logic [63:0]      eng_data,
    output logic [15:0]      eng_addr,
    output logic [KEY_W-1:0] eng_key,
    input  logic [63:0]      eng_rdata,
    output logic [15:0]      job_cnt
);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, CAP, HOLD} state_t;

    localparam logic [7:0] WDOG_LIM = TIMEOUT[7:0];

    state_t           state, state_d;
    logic [7:0]       wdog, wdog_d;
    logic             awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic             res_valid_d, res_err_d;
    logic [63:0]      res_data_d, eng_data_d;
    logic [15:0]      eng_addr_d, job_cnt_d;
    logic [KEY_W-1:0] eng_key_d;
    logic             expired, abort;

    assign cmd_ready = (state == IDLE);
    assign expired   = (wdog == WDOG_LIM);

    always_comb begin
        state_d     = state;
        wdog_d      = wdog;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        bready_d    = bready;
        arvalid_d   = arvalid;
        rready_d    = rready;
        res_valid_d = res_valid;
        res_err_d   = res_err;
        res_data_d  = res_data;
        eng_data_d  = eng_data;
        eng_addr_d  = eng_addr;
        eng_key_d   = eng_key;
        job_cnt_d   = job_cnt;
        abort       = 1'b0;

        if (state inside {AW, W, B, AR, R})
            wdog_d = wdog + 8'd1;

        // Handshake is tested before the watchdog so a same-cycle completion wins.
        case (state)
            IDLE: if (cmd_valid) begin
                eng_data_d = cmd_data;
                eng_addr_d = cmd_addr;
                eng_key_d  = cmd_key;
                state_d    = AW;
            end
            AW: if (awvalid && awready) begin awvalid_d = 1'b0; state_d = W; end
                else if (expired) abort = 1'b1;
                else awvalid_d = 1'b1;
            W:  if (wvalid && wready) begin wvalid_d = 1'b0; state_d = B; end
                else if (expired) abort = 1'b1;
                else wvalid_d = 1'b1;
            B:  if (bvalid && bready) begin bready_d = 1'b0; state_d = AR; end
                else if (expired) abort = 1'b1;
                else bready_d = 1'b1;
            AR: if (arvalid && arready) begin arvalid_d = 1'b0; state_d = R; end
                else if (expired) abort = 1'b1;
                else arvalid_d = 1'b1;
            R:  if (rready) begin rready_d = 1'b0; state_d = CAP; end
                else if (rvalid) rready_d = 1'b1;
                else if (expired) abort = 1'b1;
            CAP: begin
                res_data_d  = eng_rdata;
                res_valid_d = 1'b1;
                res_err_d   = 1'b0;
                job_cnt_d   = job_cnt + 16'd1;
                state_d     = HOLD;
            end
            HOLD: if (res_ready) begin res_valid_d = 1'b0; state_d = IDLE; end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            res_data_d  = '0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = HOLD;
        end

        if (state_d != state)
            wdog_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wdog      <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            res_data  <= '0;
            eng_data  <= '0;
            eng_addr  <= '0;
            eng_key   <= '0;
            job_cnt   <= '0;
        end else begin
            state     <= state_d;
            wdog      <= wdog_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            bready    <= bready_d;
            arvalid   <= arvalid_d;
            rready    <= rready_d;
            res_valid <= res_valid_d;
            res_err   <= res_err_d;
            res_data  <= res_data_d;
            eng_data  <= eng_data_d;
            eng_addr  <= eng_addr_d;
            eng_key   <= eng_key_d;
            job_cnt   <= job_cnt_d;
        end
    end

endmodule

// File: tb/tb_ravan_axi_master.sv
// Scenario bench for ravan_axi_master: scoreboard of expected results, engine returns
// held high by default and withheld per scenario.
module tb_ravan_axi_master;

    localparam int KEY_W = 512;
    localparam int TO    = 16;

    logic             clk = 0, rst = 0;
    logic             cmd_valid = 0, cmd_ready;
    logic [63:0]      cmd_data = '0;
    logic [15:0]      cmd_addr = '0;
    logic [KEY_W-1:0] cmd_key = '0;
    logic             res_valid, res_ready = 0, res_err;
    logic [63:0]      res_data;
    logic             awvalid, wvalid, bready, arvalid, rready;
    logic             awready = 1, wready = 1, bvalid = 1, arready = 1, rvalid = 1;
    logic [63:0]      eng_data, eng_rdata = '0;
    logic [15:0]      eng_addr, job_cnt;
    logic [KEY_W-1:0] eng_key;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt = 0;
    int          nchk = 0, nerr = 0, hs_multi = 0;

    ravan_axi_master #(.TIMEOUT(TO), .KEY_W(KEY_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_addr(cmd_addr), .cmd_key(cmd_key),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .awvalid(awvalid), .wvalid(wvalid), .bready(bready), .arvalid(arvalid), .rready(rready),
        .awready(awready), .wready(wready), .bvalid(bvalid), .arready(arready), .rvalid(rvalid),
        .eng_data(eng_data), .eng_addr(eng_addr), .eng_key(eng_key),
        .eng_rdata(eng_rdata), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ($countones({awvalid, wvalid, bready, arvalid, rready}) > 1) hs_multi++;

    // Presents a command, waits for acceptance and records the predicted result.
    // Returns on the falling edge right after the accept edge.
    task automatic send(input logic [63:0] d, input logic [15:0] a, input logic [KEY_W-1:0] k,
                        input logic [63:0] rdat, input logic err);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_data = d; cmd_addr = a; cmd_key = k; eng_rdata = rdat;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        if (!err) exp_cnt = exp_cnt + 16'd1;
        e.data = err ? 64'd0 : rdat; e.err = err; e.cnt = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // Waits (bounded) for res_valid, hands back observed and expected, then consumes it.
    task automatic get_result(input int max, output int lat, output exp_t got, output exp_t exp);
        lat = 0;
        while (!res_valid && lat < max) begin @(negedge clk); lat++; end
        got.data = res_data; got.err = res_err; got.cnt = job_cnt;
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
    endtask

    task automatic test_reset();
        nchk++;
        if ({awvalid, wvalid, bready, arvalid, rready, res_valid, res_err, res_data, job_cnt,
             eng_data, eng_addr, eng_key} !== '0) begin
            nerr++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        @(negedge clk); rst = 1;
        @(negedge clk);
        nchk++;
        if (cmd_ready !== 1'b1 || job_cnt !== 16'd0) begin
            nerr++; $display("FAIL reset_release: cmd_ready=%b job_cnt=%0d want 1/0", cmd_ready, job_cnt);
        end
    endtask

    task automatic test_nominal();
        int lat; exp_t got, exp;
        send(64'h0123456789ABCDEF, 16'h0010, {8{64'h1111_2222_3333_4444}}, 64'hDEADBEEFCAFEF00D, 0);
        nchk++;
        if (eng_data !== 64'h0123456789ABCDEF || eng_addr !== 16'h0010) begin
            nerr++; $display("FAIL nominal_eng: eng_data=%h eng_addr=%h", eng_data, eng_addr);
        end
        get_result(40, lat, got, exp);
        nchk++;
        if (got !== exp || got.cnt !== 16'd1) begin
            nerr++; $display("FAIL nominal_result: got %h/%b/%0d want %h/%b/%0d",
                             got.data, got.err, got.cnt, exp.data, exp.err, exp.cnt);
        end
        nchk++;
        if (lat != 11) begin nerr++; $display("FAIL nominal_latency: got %0d want 11", lat); end
    endtask

    task automatic test_back_to_back();
        int lat, n = 0, viol = 0; exp_t got, exp;
        send(64'hAAAA_0000_0000_0001, 16'h0100, '0, 64'h5555_0000_0000_0001, 0);
        cmd_valid = 1; cmd_data = 64'hBBBB_0000_0000_0002; cmd_addr = 16'h0200;
        while (!res_valid && n < 40) begin @(negedge clk); n++; end
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready !== 1'b0 || res_valid !== 1'b1) viol++;
            @(negedge clk);
        end
        nchk++;
        if (viol != 0 || eng_data !== 64'hAAAA_0000_0000_0001) begin
            nerr++; $display("FAIL backpressure_hold: viol=%0d eng_data=%h", viol, eng_data);
        end
        get_result(5, lat, got, exp);
        nchk++;
        if (got !== exp) begin
            nerr++; $display("FAIL backpressure_first: got %h/%0d want %h/%0d", got.data, got.cnt, exp.data, exp.cnt);
        end
        nchk++;
        if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL second_ready: cmd_ready=%b want 1", cmd_ready); end
        eng_rdata = 64'h6666_0000_0000_0002;
        @(posedge clk);
        exp_cnt = exp_cnt + 16'd1;
        sb.push_back('{data: 64'h6666_0000_0000_0002, err: 1'b0, cnt: exp_cnt});
        @(negedge clk); cmd_valid = 0;
        get_result(40, lat, got, exp);
        nchk++;
        if (got !== exp || lat != 11) begin
            nerr++; $display("FAIL second_job: got %h/%0d lat %0d want %h/%0d lat 11",
                             got.data, got.cnt, lat, exp.data, exp.cnt);
        end
    endtask

    task automatic test_timeout();
        int lat; exp_t got, exp;
        arready = 0;
        send(64'h1234, 16'h0030, '0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        while (!res_valid && lat < 100) begin @(negedge clk); lat++; end
        nchk++;
        if (arvalid !== 1'b0) begin nerr++; $display("FAIL timeout_arvalid: arvalid=%b want 0", arvalid); end
        get_result(100, lat, got, exp);
        nchk++;
        if (got !== exp) begin
            nerr++; $display("FAIL timeout_result: got %h/%b/%0d want %h/%b/%0d",
                             got.data, got.err, got.cnt, exp.data, exp.err, exp.cnt);
        end
        arready = 1;
    endtask

    task automatic test_tie();
        int lat, n = 0; exp_t got, exp;
        wready = 0;
        send(64'h7777, 16'h0040, '0, 64'h0BAD_F00D_0000_7777, 0);
        while (!wvalid && n < 20) begin @(negedge clk); n++; end
        // wvalid first seen with watchdog at 1; fifteen edges later it sits at TIMEOUT.
        repeat (TO - 1) @(negedge clk);
        wready = 1;
        @(negedge clk);
        nchk++;
        if (wvalid !== 1'b0 || res_valid !== 1'b0) begin
            nerr++; $display("FAIL tie_w_done: wvalid=%b res_valid=%b want 0/0", wvalid, res_valid);
        end
        @(negedge clk);
        nchk++;
        if (bready !== 1'b1) begin nerr++; $display("FAIL tie_enter_b: bready=%b want 1", bready); end
        get_result(40, lat, got, exp);
        nchk++;
        if (got !== exp) begin
            nerr++; $display("FAIL tie_result: got %h/%b/%0d want %h/%b/%0d",
                             got.data, got.err, got.cnt, exp.data, exp.err, exp.cnt);
        end
    endtask

    task automatic test_reset_mid_w();
        int lat, n = 0; exp_t got, exp;
        wready = 0;
        send(64'h9999, 16'h0050, {KEY_W{1'b1}}, 64'h1, 0);
        while (!wvalid && n < 20) begin @(negedge clk); n++; end
        void'(sb.pop_back());
        #2 rst = 0;
        #1;
        nchk++;
        if ({awvalid, wvalid, bready, arvalid, rready, res_valid, res_err, res_data, job_cnt,
             eng_data, eng_addr, eng_key} !== '0 || cmd_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_mid_w: wvalid=%b job_cnt=%0d eng_data=%h cmd_ready=%b",
                             wvalid, job_cnt, eng_data, cmd_ready);
        end
        exp_cnt = 0; wready = 1;
        @(negedge clk); rst = 1;
        send(64'hCCCC, 16'h0060, '0, 64'hFACE_0000_0000_CCCC, 0);
        get_result(40, lat, got, exp);
        nchk++;
        if (got !== exp || lat != 11) begin
            nerr++; $display("FAIL after_reset_job: got %h/%0d lat %0d want %h/%0d lat 11",
                             got.data, got.cnt, lat, exp.data, exp.cnt);
        end
    endtask

    task automatic test_wrap();
        int lat; exp_t got, exp;
        @(negedge clk);
        force dut.job_cnt = 16'hFFFF;
        #1 release dut.job_cnt;
        exp_cnt = 16'hFFFF;
        send(64'hEEEE, 16'h0070, '0, 64'h0000_0000_0000_EEEE, 0);
        get_result(40, lat, got, exp);
        nchk++;
        if (got !== exp || got.cnt !== 16'd0) begin
            nerr++; $display("FAIL wrap: job_cnt=%0d want 0 (data %h want %h)", got.cnt, got.data, exp.data);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_timeout();
        test_tie();
        test_reset_mid_w();
        test_wrap();
        nchk++;
        if (hs_multi != 0) begin nerr++; $display("FAIL handshake_onehot: %0d cycles with >1 high", hs_multi); end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
